ae18_stack: RTL and testbench

AE18_STACK -- requirements
Module: ae18_stack

---
 rtl/ae18_stack_pkg.sv | 34 +++
 rtl/ae18_stack.sv | 120 ++++++++++++
 tb/tb_ae18_stack.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ae18_stack_pkg.sv
// ============================================================================
// Module : ae18_stack_pkg
// Brief  : Shared AE18 constants: stack and RAM geometry, stack command codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ae18_stack_pkg;

  localparam int ISIZ_DEF   = 24;
  localparam int SSIZ_DEF   = 5;

  // The hardware stack RAM is exactly one return address wide and one sp deep.
  localparam int RAM_AW_DEF = SSIZ_DEF;
  localparam int RAM_DW_DEF = ISIZ_DEF;

  function automatic int stack_max(input int ssiz);
    return (1 << ssiz) - 1;
  endfunction

  localparam int MAX_DEF = stack_max(SSIZ_DEF);

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_SPLD = 3'd1,
    CMD_PUSH = 3'd2,
    CMD_REPL = 3'd3,
    CMD_POP  = 3'd4,
    CMD_TOSW = 3'd5
  } cmd_e;

endpackage

`default_nettype wire

// File: rtl/ae18_stack.sv
// ============================================================================
// Module : ae18_stack
// Brief  : AE18 return-address stack controller driving an external sync RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ae18_stack
  import ae18_stack_pkg::*;
#(
  parameter int ISIZ = ISIZ_DEF,
  parameter int SSIZ = SSIZ_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [ISIZ-1:0] pdat,
  input  logic            tos_we,
  input  logic            sp_we,
  input  logic [SSIZ-1:0] sp_wdat,
  input  logic            flg_clr,
  input  logic            stvren,
  output logic [ISIZ-1:0] tos,
  output logic [SSIZ-1:0] sp,
  output logic            ful,
  output logic            unf,
  output logic            srst,
  output logic            ram_we,
  output logic [SSIZ-1:0] ram_wadr,
  output logic [ISIZ-1:0] ram_wdat,
  output logic [SSIZ-1:0] ram_radr,
  input  logic [ISIZ-1:0] ram_rdat
);

  localparam logic [SSIZ-1:0] MAX = SSIZ'(stack_max(SSIZ));

  logic [SSIZ-1:0] sp_q, sp_d;
  logic            ful_q, ful_d;
  logic            unf_q, unf_d;
  logic            srst_q, srst_d;

  cmd_e            cmd;
  logic            sp_zero, sp_max;
  logic            we, ovf, udf;
  logic [SSIZ-1:0] wadr;

  assign sp_zero = (sp_q == '0);
  assign sp_max  = (sp_q == MAX);

  // Push+pop on an empty stack has nothing to replace, so it degrades to a push.
  always_comb begin
    cmd = CMD_NONE;
    if (sp_we)                        cmd = CMD_SPLD;
    else if (push && (!pop || sp_zero)) cmd = CMD_PUSH;
    else if (push)                    cmd = CMD_REPL;
    else if (pop)                     cmd = CMD_POP;
    else if (tos_we && !sp_zero)      cmd = CMD_TOSW;
  end

  always_comb begin
    sp_d = sp_q;
    we   = 1'b0;
    wadr = sp_q;
    ovf  = 1'b0;
    udf  = 1'b0;
    case (cmd)
      CMD_SPLD: sp_d = sp_wdat;
      CMD_PUSH: begin
        if (sp_max) begin
          ovf = 1'b1;
        end else begin
          we   = 1'b1;
          wadr = sp_q + 1'b1;
          sp_d = sp_q + 1'b1;
        end
      end
      CMD_REPL, CMD_TOSW: we = 1'b1;
      CMD_POP: begin
        if (sp_zero) udf  = 1'b1;
        else         sp_d = sp_q - 1'b1;
      end
      default: ;
    endcase
  end

  // A fault in the same cycle as a clear wins.
  assign ful_d  = ovf | (ful_q & ~flg_clr);
  assign unf_d  = udf | (unf_q & ~flg_clr);
  assign srst_d = (ovf | udf) & stvren;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      ful_q  <= 1'b0;
      unf_q  <= 1'b0;
      srst_q <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      ful_q  <= ful_d;
      unf_q  <= unf_d;
      srst_q <= srst_d;
    end
  end

  // Reading at the next sp lets the synchronous RAM present the new TOS with no lag.
  assign ram_we   = we & ~rst;
  assign ram_wadr = wadr;
  assign ram_wdat = pdat;
  assign ram_radr = sp_d;

  assign tos  = sp_zero ? '0 : ram_rdat;
  assign sp   = sp_q;
  assign ful  = ful_q;
  assign unf  = unf_q;
  assign srst = srst_q;

endmodule

`default_nettype wire

// File: tb/tb_ae18_stack.sv
// ============================================================================
// Module : tb_ae18_stack
// Brief  : Scoreboard bench for ae18_stack with a write-first synchronous RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ae18_stack;

  typedef struct packed {
    logic [4:0]  sp;
    logic [23:0] tos;
    logic        ful;
    logic        unf;
    logic        srst;
  } st_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, tos_we, sp_we, flg_clr, stvren;
  logic [23:0] pdat;
  logic [4:0]  sp_wdat;
  logic [23:0] tos;
  logic [4:0]  sp;
  logic        ful, unf, srst;
  logic        ram_we;
  logic [4:0]  ram_wadr, ram_radr;
  logic [23:0] ram_wdat, ram_rdat;

  logic [23:0] mem [0:31];
  int          addr0_writes = 0;

  st_t         exp_q [$];
  st_t         obs, e;
  int          n_run  = 0;
  int          n_fail = 0;

  assign obs = {sp, tos, ful, unf, srst};

  always #5 clk = ~clk;

  ae18_stack #(.ISIZ(24), .SSIZ(5)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .pdat(pdat),
    .tos_we(tos_we), .sp_we(sp_we), .sp_wdat(sp_wdat),
    .flg_clr(flg_clr), .stvren(stvren),
    .tos(tos), .sp(sp), .ful(ful), .unf(unf), .srst(srst),
    .ram_we(ram_we), .ram_wadr(ram_wadr), .ram_wdat(ram_wdat),
    .ram_radr(ram_radr), .ram_rdat(ram_rdat)
  );

  // Environment RAM: synchronous read, write-first on an address collision.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_wadr] <= ram_wdat;
      if (ram_wadr == 5'd0) addr0_writes <= addr0_writes + 1;
    end
    ram_rdat <= (ram_we && ram_wadr == ram_radr) ? ram_wdat : mem[ram_radr];
  end

  function automatic st_t mk(input logic [4:0] s, input logic [23:0] t,
                             input logic f, input logic u, input logic r);
    mk = {s, t, f, u, r};
  endfunction

  task automatic drive(input logic pu, input logic po, input logic tw, input logic sw,
                       input logic [4:0] swd, input logic fc, input logic st,
                       input logic [23:0] pd);
    push = pu; pop = po; tos_we = tw; sp_we = sw; sp_wdat = swd;
    flg_clr = fc; stvren = st; pdat = pd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 5'd0, 0, 0, 24'h0);
    repeat (2) tick();
    n_run++;
    if ({obs, ram_we} !== 33'h0) begin
      n_fail++;
      $display("FAIL reset: got state=%h we=%b want 0", obs, ram_we);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_push3();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 5'd0, 0, 0, 24'(i) << 8);
      #1;
      n_run++;
      if ({ram_we, ram_wadr} !== {1'b1, 5'(i)}) begin
        n_fail++;
        $display("FAIL push3_wr[%0d]: got we=%b adr=%0d want we=1 adr=%0d", i, ram_we, ram_wadr, i);
      end
      exp_q.push_back(mk(5'(i), 24'(i) << 8, 0, 0, 0));
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL push3[%0d]: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_pop_underflow();
    exp_q.push_back(mk(5'd2, 24'h000200, 0, 0, 0));
    exp_q.push_back(mk(5'd1, 24'h000100, 0, 0, 0));
    exp_q.push_back(mk(5'd0, 24'h000000, 0, 0, 0));
    exp_q.push_back(mk(5'd0, 24'h000000, 0, 1, 1));
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 5'd0, 0, 1, 24'hFFFFFF);
      #1;
      n_run++;
      if (ram_we !== 1'b0) begin
        n_fail++;
        $display("FAIL pop_nowr[%0d]: got we=%b want 0", i, ram_we);
      end
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL pop[%0d]: got %h want %h", i, obs, e);
      end
    end
    // srst lasts one cycle, unf is sticky; then set-wins, then a plain clear.
    exp_q.push_back(mk(5'd0, 24'h0, 0, 1, 0));
    exp_q.push_back(mk(5'd0, 24'h0, 0, 1, 0));
    exp_q.push_back(mk(5'd0, 24'h0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      drive(0, 0, 0, 0, 5'd0, 0, 1, 24'h0);
      else if (i == 1) drive(0, 1, 0, 0, 5'd0, 1, 0, 24'h0);
      else             drive(0, 0, 0, 0, 5'd0, 1, 0, 24'h0);
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL unf_flag[%0d]: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 31; i++) begin
      drive(1, 0, 0, 0, 5'd0, 0, 0, 24'h100000 + 24'(i));
      exp_q.push_back(mk(5'(i), 24'h100000 + 24'(i), 0, 0, 0));
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL fill[%0d]: got %h want %h", i, obs, e);
      end
    end
    drive(1, 0, 0, 0, 5'd0, 0, 0, 24'hABCDEF);
    #1;
    n_run++;
    if (ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_nowr: got we=%b want 0", ram_we);
    end
    exp_q.push_back(mk(5'd31, 24'h10001F, 1, 0, 0));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL overflow: got %h want %h", obs, e);
    end
  endtask

  task automatic test_replace();
    drive(0, 0, 0, 1, 5'd2, 0, 0, 24'h0);
    exp_q.push_back(mk(5'd2, 24'h100002, 1, 0, 0));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL sp_load2: got %h want %h", obs, e);
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1, 1, 0, 0, 5'd0, 0, 0, 24'h123456);
      else        drive(0, 0, 1, 0, 5'd0, 0, 0, 24'h654321);
      #1;
      n_run++;
      if ({ram_we, ram_wadr} !== {1'b1, 5'd2}) begin
        n_fail++;
        $display("FAIL repl_wr[%0d]: got we=%b adr=%0d want we=1 adr=2", i, ram_we, ram_wadr);
      end
      exp_q.push_back(mk(5'd2, (i == 0) ? 24'h123456 : 24'h654321, 1, 0, 0));
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL replace[%0d]: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_spwe_priority();
    drive(1, 0, 0, 1, 5'd5, 0, 0, 24'h00DEAD);
    #1;
    n_run++;
    if (ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL spwe_nowr: got we=%b want 0", ram_we);
    end
    exp_q.push_back(mk(5'd5, 24'h100005, 1, 0, 0));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL spwe: got %h want %h", obs, e);
    end
  endtask

  task automatic test_empty_cases();
    drive(0, 0, 0, 1, 5'd0, 0, 0, 24'h0);
    tick();
    drive(0, 0, 1, 0, 5'd0, 0, 0, 24'h0BAD00);
    #1;
    n_run++;
    if (ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL tosw_empty: got we=%b want 0", ram_we);
    end
    exp_q.push_back(mk(5'd0, 24'h0, 1, 0, 0));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL tosw_empty_st: got %h want %h", obs, e);
    end
    drive(1, 1, 0, 0, 5'd0, 0, 0, 24'h0C0FFE);
    #1;
    n_run++;
    if ({ram_we, ram_wadr} !== {1'b1, 5'd1}) begin
      n_fail++;
      $display("FAIL pushpop_empty_wr: got we=%b adr=%0d want we=1 adr=1", ram_we, ram_wadr);
    end
    exp_q.push_back(mk(5'd1, 24'h0C0FFE, 1, 0, 0));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL pushpop_empty: got %h want %h", obs, e);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 1, 5'd7, 0, 0, 24'h0);
    tick();
    drive(1, 0, 0, 0, 5'd0, 0, 0, 24'h777777);
    rst = 1'b1;
    #1;
    n_run++;
    if ({obs, ram_we} !== 33'h0) begin
      n_fail++;
      $display("FAIL async_rst: got state=%h we=%b want 0", obs, ram_we);
    end
    #1 rst = 1'b0;
    #1;
    n_run++;
    if ({ram_we, ram_wadr} !== {1'b1, 5'd1}) begin
      n_fail++;
      $display("FAIL post_rst_wr: got we=%b adr=%0d want we=1 adr=1", ram_we, ram_wadr);
    end
    exp_q.push_back(mk(5'd1, 24'h777777, 0, 0, 0));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL post_rst: got %h want %h", obs, e);
    end
    drive(0, 0, 0, 0, 5'd0, 0, 0, 24'h0);
    tick();
  endtask

  initial begin
    test_reset();
    test_push3();
    test_pop_underflow();
    test_overflow();
    test_replace();
    test_spwe_priority();
    test_empty_cases();
    test_async_reset();
    n_run++;
    if (addr0_writes !== 0) begin
      n_fail++;
      $display("FAIL addr0_write: got %0d writes want 0", addr0_writes);
    end
    n_run++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
